// File: rtl/puf_response_serializer.sv
// puf_response_serializer
// Parallel-in, serial-out transmitter for RO-PUF response words. A WIDTH-bit
// response is captured on a load handshake and shifted out MSB first, one bit
// per cycle in which s_valid & en is high. The serial pair s_out / s_valid & en
// is intended to feed the s_in / en inputs of the 256-bit SHIFT_REGISTER
// receiver directly.
//
// Optional feature (compile-time macro PARITY_SERIAL_EN):
//   When defined, an even-parity bit (XOR of all captured bits) is appended as
//   an extra transfer after the WIDTH data bits, giving WIDTH+1 transfers per
//   word. When undefined, no parity state or parity register exists.
//
// All outputs are driven from flops that are loaded with the decode of the
// next state, so there is no combinational path from any input to any output.

module puf_response_serializer #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p_in,
    input  logic             load,
    output logic             ready,
    input  logic             en,
    output logic             s_out,
    output logic             s_valid,
    output logic             done
);

    // Bit counter width is derived from WIDTH so the counter can reach WIDTH
    // without wrapping.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef PARITY_SERIAL_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_DONE   = 2'b10,
        ST_PARITY = 2'b11
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;
`endif

`ifdef PARITY_SERIAL_EN
    // Even parity of a response word: XOR reduction of all bits.
    function automatic logic calc_even_parity(input logic [WIDTH-1:0] word);
        calc_even_parity = ^word;
    endfunction
`endif

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
`ifdef PARITY_SERIAL_EN
    logic             parity_r;
    logic             parity_s;
`endif

    logic             s_out_r;
    logic             s_out_s;
    logic             s_valid_r;
    logic             s_valid_s;
    logic             ready_r;
    logic             ready_s;
    logic             done_r;
    logic             done_s;

    // Next-state, shift register, counter and parity update logic.
    always_comb begin
        state_s  = state_r;
        shift_s  = shift_r;
        cnt_s    = cnt_r;
`ifdef PARITY_SERIAL_EN
        parity_s = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // en is ignored here; only a load starts a new word.
                if (load) begin
                    shift_s  = p_in;
                    cnt_s    = {CNT_W{1'b0}};
`ifdef PARITY_SERIAL_EN
                    parity_s = calc_even_parity(p_in);
`endif
                    state_s  = ST_SHIFT;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // A transfer happens on every enabled edge; otherwise stall.
                // load is deliberately ignored while a word is in flight.
                if (en) begin
                    shift_s = {shift_r[WIDTH-2:0], 1'b0};
                    cnt_s   = cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
`ifdef PARITY_SERIAL_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_DONE;
`endif
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
`ifdef PARITY_SERIAL_EN
            ST_PARITY: begin
                // Parity bit is presented until the receiver accepts it.
                if (en) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_DONE: begin
                // Single-cycle completion marker, then ready for the next word.
                state_s = ST_IDLE;
            end
            default: begin
                // Unreachable encoding: recover to a clean idle state.
                state_s = ST_IDLE;
                shift_s = {WIDTH{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Decode of the next state into the values the output flops will hold.
    always_comb begin
        s_out_s   = 1'b0;
        s_valid_s = 1'b0;
        ready_s   = 1'b0;
        done_s    = 1'b0;
        case (state_s)
            ST_IDLE: begin
                ready_s = 1'b1;
            end
            ST_SHIFT: begin
                s_valid_s = 1'b1;
                s_out_s   = shift_s[WIDTH-1];
            end
`ifdef PARITY_SERIAL_EN
            ST_PARITY: begin
                s_valid_s = 1'b1;
                s_out_s   = parity_s;
            end
`endif
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // State, datapath and counter registers; reset abandons any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            shift_r  <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
`ifdef PARITY_SERIAL_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            shift_r  <= shift_s;
            cnt_r    <= cnt_s;
`ifdef PARITY_SERIAL_EN
            parity_r <= parity_s;
`endif
        end
    end

    // Output flops, loaded with the decode of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_out_r   <= 1'b0;
            s_valid_r <= 1'b0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            s_out_r   <= s_out_s;
            s_valid_r <= s_valid_s;
            ready_r   <= ready_s;
            done_r    <= done_s;
        end
    end

    assign s_out   = s_out_r;
    assign s_valid = s_valid_r;
    assign ready   = ready_r;
    assign done    = done_r;

endmodule

// File: tb/tb_puf_response_serializer.sv
// Self-checking bench for puf_response_serializer: table-driven 8-bit words
// with stalls and ignored loads, a hand-written mid-word reset sequence, and a
// 256-bit loopback into a behavioural serial-in receiver.
module tb_puf_response_serializer;

    localparam int W  = 8;
    localparam int BW = 256;
`ifdef PARITY_SERIAL_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [W-1:0]  p_in;
    logic          load, en, ready, s_out, s_valid, done;
    logic [BW-1:0] big_p_in;
    logic          big_load, big_en, big_ready, big_s_out, big_s_valid, big_done;
    logic [BW-1:0] rx;

    int tests_run    = 0;
    int tests_failed = 0;

    puf_response_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .p_in(p_in), .load(load), .ready(ready),
        .en(en), .s_out(s_out), .s_valid(s_valid), .done(done)
    );

    puf_response_serializer #(.WIDTH(BW)) dut_big (
        .clk(clk), .rst(rst), .p_in(big_p_in), .load(big_load), .ready(big_ready),
        .en(big_en), .s_out(big_s_out), .s_valid(big_s_valid), .done(big_done)
    );

    // Behavioural model of the 256-bit serial-in receiver on the loopback link.
    always @(posedge clk or posedge rst) begin
        if (rst) rx <= '0;
        else if (big_s_valid && big_en) rx <= {rx[BW-2:0], big_s_out};
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] word;
        logic       exp_par;   // hand-computed even parity of word
        int         stall_at;  // transfers completed before stalling (-1: none)
        int         stall_len;
        int         inj_at;    // bit index at which a spurious load is asserted
        int         exp_done;  // cycle after load edge when done pulses (no parity)
    } vec_t;

    vec_t vecs[7];

    task automatic run_word(input vec_t v);
        logic [8:0] got;
        int nbits, done_cyc, stall_left;
        got = '0; nbits = 0; done_cyc = -1; stall_left = v.stall_len;
        @(negedge clk);
        check({v.name, ":ready_before"}, 256'(ready), 256'(1'b1));
        p_in = v.word; load = 1'b1; en = 1'b1;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            load = 1'b0;
            p_in = ~v.word;
            en   = 1'b1;
            if (done) done_cyc = cyc;
            if (s_valid) begin
                if (nbits == v.inj_at) begin
                    load = 1'b1;
                    p_in = 8'hFF;
                end
                if (nbits == v.stall_at && stall_left > 0) begin
                    en = 1'b0;
                    stall_left--;
                    check({v.name, ":stall_hold"}, 256'(s_out), 256'(v.word[7-nbits]));
                end else begin
                    got = {got[7:0], s_out};
                    nbits++;
                end
            end
        end
        load = 1'b0;
        en   = 1'b0;
        check({v.name, ":nbits"}, 256'(nbits), 256'(W + PX));
        if (PX == 1) check({v.name, ":bits"}, 256'(got), 256'({v.word, v.exp_par}));
        else         check({v.name, ":bits"}, 256'(got), 256'({1'b0, v.word}));
        check({v.name, ":done_cycle"}, 256'(done_cyc), 256'(v.exp_done + PX));
        @(negedge clk);
        check({v.name, ":ready_after"}, 256'({ready, done, s_valid}), 256'(3'b100));
    endtask

    initial begin
        vec_t v81;
        int   done_cnt;
        logic [BW-1:0] word;
        logic [BW-1:0] exp_rx;
        bit   got_done;

        vecs[0] = '{"aa_basic",      8'hAA, 1'b0, -1, 0, -1,  9};
        vecs[1] = '{"c3_stall",      8'hC3, 1'b0,  2, 3, -1, 12};
        vecs[2] = '{"0f_ign_load",   8'h0F, 1'b0, -1, 0,  3,  9};
        vecs[3] = '{"07_word",       8'h07, 1'b1, -1, 0, -1,  9};
        vecs[4] = '{"03_word",       8'h03, 1'b0, -1, 0, -1,  9};
        vecs[5] = '{"80_stall_first",8'h80, 1'b1,  0, 2, -1, 11};
        vecs[6] = '{"01_stall_last", 8'h01, 1'b1,  7, 1, -1, 10};

        rst = 1'b1; load = 1'b0; en = 1'b0; p_in = '0;
        big_load = 1'b0; big_en = 1'b0; big_p_in = '0;
        #1;
        check("reset_outputs", 256'({s_out, s_valid, done, ready}), 256'(4'b0001));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // en alone must not start anything while idle.
        en = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_en_ignored", 256'({s_valid, ready, done}), 256'(3'b010));
        en = 1'b0;

        foreach (vecs[i]) run_word(vecs[i]);

        // Mid-word reset: abort after 4 transfers of F0, no done pulse.
        @(negedge clk);
        p_in = 8'hF0; load = 1'b1; en = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_pre_bit", 256'({s_valid, s_out}), 256'(2'b10));
        rst = 1'b1;
        #1;
        check("rst_immediate", 256'({s_valid, ready, done, s_out}), 256'(4'b0100));
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst_no_done", 256'(done_cnt), 256'(0));
        en = 1'b0;
        v81 = '{"81_after_rst", 8'h81, 1'b0, -1, 0, -1, 9};
        run_word(v81);

        // 256-bit loopback with random enable gaps.
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < BW / 32; k++) word[k*32 +: 32] = $urandom;
            @(negedge clk);
            check("big_ready", 256'(big_ready), 256'(1'b1));
            big_p_in = word; big_load = 1'b1; big_en = 1'b1;
            @(negedge clk);
            big_load = 1'b0;
            big_p_in = ~word;
            got_done = 1'b0;
            for (int c = 0; c < 2000 && !got_done; c++) begin
                big_en = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (big_done) got_done = 1'b1;
            end
            big_en = 1'b0;
            check("big_done_seen", 256'(got_done), 256'(1'b1));
            if (PX == 1) exp_rx = {word[BW-2:0], ^word};
            else         exp_rx = word;
            check("big_loopback", rx, exp_rx);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
